multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM that sequences a shared-memory multi-cycle MIPS datapath: RF, ALU, ALU_Controller and PC/IR regs.
//  Drives all mux selects and write enables, one instruction step per state.
//  Stretches memory states on a ready handshake and traps illegal opcodes and memory timeouts.
// PARAMETERS
//  MAX_WAIT   15  max consecutive !MemReady cycles in any memory state before Fault (1..255)
//  CNT_WIDTH  32  width of performance counters (used only with MC_PERF_CNT_EN)
// PORTS
//  Clk          in   1  clock, rising edge
//  Rst          in   1  asynchronous, active-low reset
//  OpCode       in   6  IR[31:26], valid from DECODE onward
//  Zero         in   1  ALU zero flag
//  MemReady     in   1  memory completes access this cycle
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load if Zero (beq)
//  IorD         out  1  0=PC addresses memory, 1=ALUOut
//  MemRead      out  1  memory read request
//  MemWrite     out  1  memory write request
//  IRWrite      out  1  instruction register load
//  MemToReg     out  1  0=ALUOut, 1=MDR to RF write data
//  RegDst       out  1  0=rt, 1=rd
//  RegWrite     out  1  RF write enable
//  ALUSrcA      out  1  0=PC, 1=RF A
//  ALUSrcB      out  2  00=B, 01=4, 10=SE imm, 11=SE imm<<2
//  ALUOp        out  2  00=add, 01=sub, 10=funct-decoded
//  PCSource     out  2  00=ALU result, 01=ALUOut, 10=jump target
//  IllegalOp    out  1  one-cycle pulse in DECODE on unknown opcode
//  Fault        out  1  sticky memory-timeout flag
// BEHAVIOUR
//  - Reset: state=FETCH, WaitCnt=0, Fault=0, IllegalOp=0.
//  - Reset: all other outputs take their FETCH/!MemReady values.
//  - Opcodes: R=6'h00, LW=6'h23, SW=6'h2B, BEQ=6'h04, J=6'h02, ADDI=6'h08.
//  - States and transitions:
//    FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
//      IRWrite=PCWrite=MemReady.
//      MemReady -> DECODE; else stay in FETCH.
//    DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
//      R->EXEC_R, LW/SW->ADDR, BEQ->BRANCH, J->JUMP, ADDI->EXEC_I.
//      Any other opcode: IllegalOp=1 -> FETCH, no writes.
//    ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW->MEM_RD, SW->MEM_WR.
//    MEM_RD: MemRead=1, IorD=1. MemReady -> WB_MEM.
//    MEM_WR: MemWrite=1, IorD=1. MemReady -> FETCH.
//    WB_MEM: RegWrite=1, MemToReg=1, RegDst=0 -> FETCH.
//    EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB_ALU_R.
//    WB_ALU_R: RegWrite=1, RegDst=1, MemToReg=0 -> FETCH.
//    EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> WB_ALU_I.
//    WB_ALU_I: RegWrite=1, RegDst=0 -> FETCH.
//    BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
//    JUMP: PCWrite=1, PCSource=10 -> FETCH.
//    FAULT: all enables 0, Fault=1. Only reset exits.
//  - Unlisted outputs are 0 in every state. MemRead and MemWrite are never both 1.
//  - Wait counter:
//    WaitCnt increments each cycle spent in FETCH/MEM_RD/MEM_WR with MemReady=0.
//    Clears on MemReady=1 or on any state change.
//    On the cycle WaitCnt==MAX_WAIT with MemReady=0 -> FAULT next cycle; no write enable pulses.
//  - Latency in cycles with zero wait: R/ADDI=4, LW=5, SW=4, BEQ=3, J=3.
//  - MemReady outside memory states is ignored.
//  - Rst assertion mid-instruction: immediate return to FETCH; the partial instruction is abandoned, no writes.
// CONFIGURATION
//  MC_PERF_CNT_EN defined:
//    adds outputs CycleCnt and RetireCnt, each CNT_WIDTH wide; both reset to 0.
//    CycleCnt increments every cycle not in FAULT.
//    RetireCnt increments on transition into FETCH from a completing state (WB_*, MEM_WR, BRANCH, JUMP).
//    Illegal-op returns are not counted. Both counters wrap modulo 2^CNT_WIDTH.
//  MC_PERF_CNT_EN undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  Shared package multicycle_pkg: state encoding localparams, opcode constants, ALUOp/ALUSrcB/PCSource encodings.
//  The same package is reused by DatapathController and ALU_Controller.
//  One sub-module: mc_perf_counter (enable-gated wrapping counter), instantiated twice under MC_PERF_CNT_EN.
// TESTING
//  1. Rst low mid-EXEC_R, then high
//     -> FETCH next edge, RegWrite never pulses, WaitCnt=0.
//  2. lw (6'h23), MemReady held low 3 cycles in MEM_RD
//     -> 3 extra MEM_RD cycles, single RegWrite+MemToReg pulse in WB_MEM, total 8 cycles.
//  3. beq with Zero=1, then beq with Zero=0
//     -> PCWriteCond=1 and PCSource=01 in BRANCH both times; 3 cycles each.
//  4. OpCode=6'h3F
//     -> IllegalOp pulses 1 cycle in DECODE, next state FETCH, no RegWrite/MemWrite.
//  5. MemReady stuck low in FETCH, MAX_WAIT=15
//     -> Fault=1 after cycle 16, all enables 0, held until Rst.
//  6. MC_PERF_CNT_EN, CNT_WIDTH=4: 5 R-type instrs
//     -> RetireCnt=5, CycleCnt=20 mod 16 = 4.

Source files
------------

// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared encodings for the multi-cycle MIPS control path.
// Holds the state enum, opcodes and the ALU / mux select codes.
package multicycle_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_ADDR     = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WR   = 4'd4,
      S_WB_MEM   = 4'd5,
      S_EXEC_R   = 4'd6,
      S_WB_ALU_R = 4'd7,
      S_EXEC_I   = 4'd8,
      S_WB_ALU_I = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_FAULT    = 4'd12
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_ADDI = 6'h08;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States whose exit to FETCH completes an instruction
   function automatic logic is_retire_state(input state_t s);
      return (s == S_WB_MEM)   || (s == S_WB_ALU_R) ||
             (s == S_WB_ALU_I) || (s == S_MEM_WR)   ||
             (s == S_BRANCH)   || (s == S_JUMP);
   endfunction

endpackage

// File: rtl/multicycle_controller_perf_counter.sv
// mc_perf_counter: enable-gated wrapping event counter.
// Cleared by the asynchronous active-low reset.
module mc_perf_counter #(
   parameter int unsigned W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_en,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   // Count enabled cycles, wrapping naturally at 2^W
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_cnt <= '0;
      else if (i_en) r_cnt <= r_cnt + W'(1);
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a shared-memory multi-cycle MIPS datapath.
// Optional MC_PERF_CNT_EN adds CycleCnt/RetireCnt performance counters.
module multicycle_controller
   import multicycle_pkg::*;
#(
   parameter int unsigned MAX_WAIT  = 15,
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [5:0]           OpCode,
   input  logic                 Zero,
   input  logic                 MemReady,
   output logic                 PCWrite,
   output logic                 PCWriteCond,
   output logic                 IorD,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic                 MemToReg,
   output logic                 RegDst,
   output logic                 RegWrite,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ALUOp,
   output logic [1:0]           PCSource,
   output logic                 IllegalOp,
`ifdef MC_PERF_CNT_EN
   output logic [CNT_WIDTH-1:0] CycleCnt,
   output logic [CNT_WIDTH-1:0] RetireCnt,
`endif
   output logic                 Fault
);

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_wait_cnt;
   logic [7:0] w_wait_nxt;
   logic       w_stall;
   logic       w_timeout;
   logic       w_unused_zero;

   // Zero is consumed by the datapath through PCWriteCond
   assign w_unused_zero = Zero;

   // Next-state decode; memory states stall while MemReady is low
   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      unique case (r_state)
         S_FETCH:  if (MemReady) w_next = S_DECODE;
                   else w_stall = 1'b1;
         S_DECODE: begin
            case (OpCode)
               OP_R:         w_next = S_EXEC_R;
               OP_LW, OP_SW: w_next = S_ADDR;
               OP_BEQ:       w_next = S_BRANCH;
               OP_J:         w_next = S_JUMP;
               OP_ADDI:      w_next = S_EXEC_I;
               default:      w_next = S_FETCH;
            endcase
         end
         S_ADDR:   w_next = (OpCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: if (MemReady) w_next = S_WB_MEM;
                   else w_stall = 1'b1;
         S_MEM_WR: if (MemReady) w_next = S_FETCH;
                   else w_stall = 1'b1;
         S_EXEC_R: w_next = S_WB_ALU_R;
         S_EXEC_I: w_next = S_WB_ALU_I;
         S_WB_MEM, S_WB_ALU_R, S_WB_ALU_I,
         S_BRANCH, S_JUMP: w_next = S_FETCH;
         S_FAULT:  w_next = S_FAULT;
         default:  w_next = S_FETCH;
      endcase
      w_timeout  = w_stall && (r_wait_cnt == 8'(MAX_WAIT));
      w_wait_nxt = (w_stall && !w_timeout) ? r_wait_cnt + 8'd1 : 8'd0;
      if (w_timeout) w_next = S_FAULT;
   end

   // State and wait counter registers
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state    <= S_FETCH;
         r_wait_cnt <= 8'd0;
      end else begin
         r_state    <= w_next;
         r_wait_cnt <= w_wait_nxt;
      end
   end

   // Moore control word per state; FETCH loads PC/IR only on a completed read
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemToReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_REG;
      ALUOp       = ALUOP_ADD;
      PCSource    = PCSRC_ALU;
      IllegalOp   = 1'b0;
      Fault       = 1'b0;
      unique case (r_state)
         S_FETCH: begin
            MemRead  = 1'b1;
            ALUSrcB  = SRCB_FOUR;
            IRWrite  = MemReady & Rst;
            PCWrite  = MemReady & Rst;
         end
         S_DECODE: begin
            ALUSrcB   = SRCB_IMM_SH2;
            IllegalOp = (w_next == S_FETCH);
         end
         S_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEM_RD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEM_WR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_WB_MEM: begin
            RegWrite = 1'b1;
            MemToReg = 1'b1;
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
         end
         S_WB_ALU_R: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_WB_ALU_I: RegWrite = 1'b1;
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
         end
         S_FAULT:  Fault = 1'b1;
         default: ;
      endcase
   end

`ifdef MC_PERF_CNT_EN
   logic w_cyc_en;
   logic w_ret_en;

   assign w_cyc_en = (r_state != S_FAULT);
   assign w_ret_en = is_retire_state(r_state) && (w_next == S_FETCH);

   mc_perf_counter #(.W(CNT_WIDTH)) u_cycle_cnt (
      .i_clk   (Clk),
      .i_rst_n (Rst),
      .i_en    (w_cyc_en),
      .o_cnt   (CycleCnt)
   );

   mc_perf_counter #(.W(CNT_WIDTH)) u_retire_cnt (
      .i_clk   (Clk),
      .i_rst_n (Rst),
      .i_en    (w_ret_en),
      .o_cnt   (RetireCnt)
   );
`else
   logic [CNT_WIDTH-1:0] w_unused_cnt;
   assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of the multi-cycle controller.
// Control word compared per cycle against hand-derived constants.
module tb_multicycle_controller;

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic [5:0] OpCode = 6'h00;
   logic       Zero = 1'b0;
   logic       MemReady = 1'b0;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemToReg, RegDst, RegWrite, ALUSrcA, IllegalOp, Fault;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
`ifdef MC_PERF_CNT_EN
   logic [3:0] CycleCnt, RetireCnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   multicycle_controller #(.MAX_WAIT(15), .CNT_WIDTH(4)) dut (
      .Clk(Clk), .Rst(Rst), .OpCode(OpCode), .Zero(Zero),
      .MemReady(MemReady), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .PCSource(PCSource), .IllegalOp(IllegalOp),
`ifdef MC_PERF_CNT_EN
      .CycleCnt(CycleCnt), .RetireCnt(RetireCnt),
`endif
      .Fault(Fault)
   );

   // {PCW,PCWC,IorD,MRd,MWr,IRW,M2R,RDst,RW,SrcA,SrcB[2],ALUOp[2],PCSrc[2],Ill,Fault}
   wire [17:0] w_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                        IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA,
                        ALUSrcB, ALUOp, PCSource, IllegalOp, Fault};

   localparam logic [17:0] E_FETCH_W = {10'b0001000000, 2'b01, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] E_FETCH_R = {10'b1001010000, 2'b01, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] E_DECODE  = {10'b0000000000, 2'b11, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] E_DEC_ILL = {10'b0000000000, 2'b11, 2'b00, 2'b00, 2'b10};
   localparam logic [17:0] E_ADDR    = {10'b0000000001, 2'b10, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] E_MEMRD   = {10'b0011000000, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] E_MEMWR   = {10'b0010100000, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] E_WBMEM   = {10'b0000001010, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] E_EXECR   = {10'b0000000001, 2'b00, 2'b10, 2'b00, 2'b00};
   localparam logic [17:0] E_WBR     = {10'b0000000110, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] E_EXECI   = {10'b0000000001, 2'b10, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] E_WBI     = {10'b0000000010, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] E_BR      = {10'b0100000001, 2'b00, 2'b01, 2'b01, 2'b00};
   localparam logic [17:0] E_J       = {10'b1000000000, 2'b00, 2'b00, 2'b10, 2'b00};
   localparam logic [17:0] E_FAULT   = {10'b0000000000, 2'b00, 2'b00, 2'b00, 2'b01};

   task automatic chk(input string tag, input logic [17:0] obs,
                      input logic [17:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs, check the control word, advance one clock
   task automatic cyc(input string tag, input logic rdy,
                      input logic [5:0] op, input logic [17:0] exp);
      MemReady = rdy;
      OpCode   = op;
      #2;
      chk(tag, w_ctl, exp);
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Rst      = 1'b0;
      MemReady = 1'b1;
      #2;
      chk("reset_ctl", w_ctl, E_FETCH_W);
      @(posedge Clk);
      #1;
      Rst = 1'b1;
   endtask

   initial begin
      do_reset();

      // R-type: 4 cycles
      cyc("r_fetch", 1'b1, 6'h00, E_FETCH_R);
      cyc("r_dec",   1'b0, 6'h00, E_DECODE);
      cyc("r_exec",  1'b1, 6'h00, E_EXECR);
      cyc("r_wb",    1'b0, 6'h00, E_WBR);

      // ADDI: 4 cycles
      cyc("i_fetch", 1'b1, 6'h08, E_FETCH_R);
      cyc("i_dec",   1'b0, 6'h08, E_DECODE);
      cyc("i_exec",  1'b0, 6'h08, E_EXECI);
      cyc("i_wb",    1'b0, 6'h08, E_WBI);

      // LW with 3 stalled MEM_RD cycles: 8 cycles
      cyc("lw_fetch", 1'b1, 6'h23, E_FETCH_R);
      cyc("lw_dec",   1'b0, 6'h23, E_DECODE);
      cyc("lw_addr",  1'b1, 6'h23, E_ADDR);
      for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", 1'b0, 6'h23, E_MEMRD);
      cyc("lw_memrd", 1'b1, 6'h23, E_MEMRD);
      cyc("lw_wb",    1'b0, 6'h23, E_WBMEM);

      // SW with 15 stalls in MEM_WR (one short of timeout)
      cyc("sw_fetch", 1'b1, 6'h2B, E_FETCH_R);
      cyc("sw_dec",   1'b0, 6'h2B, E_DECODE);
      cyc("sw_addr",  1'b0, 6'h2B, E_ADDR);
      for (int i = 0; i < 15; i++) cyc("sw_memwr_wait", 1'b0, 6'h2B, E_MEMWR);
      cyc("sw_memwr", 1'b1, 6'h2B, E_MEMWR);

      // BEQ taken then not taken: 3 cycles each
      Zero = 1'b1;
      cyc("beq1_fetch", 1'b1, 6'h04, E_FETCH_R);
      cyc("beq1_dec",   1'b0, 6'h04, E_DECODE);
      cyc("beq1_br",    1'b0, 6'h04, E_BR);
      Zero = 1'b0;
      cyc("beq0_fetch", 1'b1, 6'h04, E_FETCH_R);
      cyc("beq0_dec",   1'b0, 6'h04, E_DECODE);
      cyc("beq0_br",    1'b1, 6'h04, E_BR);

      // J: 3 cycles
      cyc("j_fetch", 1'b1, 6'h02, E_FETCH_R);
      cyc("j_dec",   1'b1, 6'h02, E_DECODE);
      cyc("j_jump",  1'b0, 6'h02, E_J);

      // Illegal opcode pulses once, then back in FETCH
      cyc("ill_fetch", 1'b1, 6'h3F, E_FETCH_R);
      cyc("ill_dec",   1'b0, 6'h3F, E_DEC_ILL);
      cyc("ill_next",  1'b0, 6'h3F, E_FETCH_W);

      // Reset asserted in EXEC_R abandons the instruction
      cyc("rr_fetch", 1'b1, 6'h00, E_FETCH_R);
      cyc("rr_dec",   1'b0, 6'h00, E_DECODE);
      MemReady = 1'b0;
      #1;
      chk("rr_exec", w_ctl, E_EXECR);
      Rst = 1'b0;
      #1;
      chk("rr_async", w_ctl, E_FETCH_W);
      @(posedge Clk);
      #1;
      chk("rr_hold", w_ctl, E_FETCH_W);
      Rst = 1'b1;

      // FETCH stuck: 16 waiting cycles, then sticky FAULT
      for (int i = 0; i < 16; i++) cyc("to_fetch_wait", 1'b0, 6'h00, E_FETCH_W);
      cyc("to_fault0", 1'b1, 6'h00, E_FAULT);
      cyc("to_fault1", 1'b1, 6'h23, E_FAULT);
      cyc("to_fault2", 1'b0, 6'h3F, E_FAULT);

      // Only reset leaves FAULT; then 5 R-types from a clean start
      do_reset();
      for (int n = 0; n < 5; n++) begin
         cyc("p_fetch", 1'b1, 6'h00, E_FETCH_R);
         cyc("p_dec",   1'b0, 6'h00, E_DECODE);
         cyc("p_exec",  1'b0, 6'h00, E_EXECR);
         cyc("p_wb",    1'b0, 6'h00, E_WBR);
      end
`ifdef MC_PERF_CNT_EN
      chk("retire_cnt", 18'(RetireCnt), 18'd5);
      chk("cycle_cnt",  18'(CycleCnt),  18'd4);
`endif
      cyc("p_end", 1'b0, 6'h00, E_FETCH_W);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
